// File: rtl/y_pkg.sv
// Shared types and sizes for the Y SRAM writeback block.
package y_pkg;

  localparam int ADDR_W = 11;
  localparam int ROW_W  = 256;
  localparam int LANE_W = 64;
  localparam int VAL_W  = 48;
  localparam int NLANES = ROW_W / LANE_W;

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} wb_state_t;

  typedef logic [ROW_W-1:0] y_row_t;

  // True when exactly one lane is selected.
  function automatic logic is_onehot(input logic [NLANES-1:0] v);
    return (v != '0) && ((v & (v - NLANES'(1))) == '0);
  endfunction

endpackage

// File: rtl/y_sram_writeback_if.sv
// Update-request handshake from the Y-update datapath into the writeback block.
interface y_sram_writeback_if
  import y_pkg::*;
  ();

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [NLANES-1:0] wb_oneHot;
  logic [VAL_W-1:0]  wb_val;
  logic              wb_lastIn;

  modport master (
    output wb_valid, wb_addr, wb_oneHot, wb_val, wb_lastIn,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_addr, wb_oneHot, wb_val, wb_lastIn,
    output wb_ready
  );

endinterface

// File: rtl/y_lane_merge.sv
// Replaces the Y value field of the selected lane; tags and all other lanes pass through.
module y_lane_merge
  import y_pkg::*;
(
  input  y_row_t            base_row,
  input  logic [NLANES-1:0] oneHot,
  input  logic [VAL_W-1:0]  val,
  output y_row_t            merged_row
);

  // Overwrite bits [47:0] of each selected lane, keep the column tag.
  always_comb begin
    merged_row = base_row;
    for (int k = 0; k < NLANES; k++) begin
      if (oneHot[k]) merged_row[k*LANE_W +: VAL_W] = val;
    end
  end

endmodule

// File: rtl/y_sram_writeback.sv
// Read-modify-write of Y SRAM rows with last-row forwarding, error and completion tracking.
module y_sram_writeback
  import y_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  y_sram_writeback_if.slave   wb,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  y_row_t              mem_rd_data,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output y_row_t              mem_wr_data,
  output logic [15:0]         wb_count,
  output logic                wb_err,
  output logic                wb_allDone
);

  wb_state_t         r_state;
  logic              r_ready;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  y_row_t            r_wr_data;
  logic [15:0]       r_count;
  logic              r_err;
  logic              r_alldone;
  logic              r_last_pend;
  logic              r_fwd_valid;
  logic [ADDR_W-1:0] r_fwd_addr;
  y_row_t            r_fwd_row;
  logic [ADDR_W-1:0] r_addr;
  logic [NLANES-1:0] r_onehot;
  logic [VAL_W-1:0]  r_val;

  logic              w_in_idle;
  logic              w_accept;
  logic              w_oh_ok;
  logic              w_fwd_hit;
  logic              w_commit;
  logic [ADDR_W-1:0] w_commit_addr;
  logic              w_next_idle;
  logic              w_done_fire;
  y_row_t            w_base;
  logic [NLANES-1:0] w_sel;
  logic [VAL_W-1:0]  w_mval;
  y_row_t            w_merged;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = wb.wb_valid & r_ready;
  assign w_oh_ok   = is_onehot(wb.wb_oneHot);
  assign w_fwd_hit = r_fwd_valid && (wb.wb_addr == r_fwd_addr);

  // A row is committed either straight from IDLE on a forward hit or after the SRAM read returns.
  assign w_commit      = (w_in_idle && w_accept && w_oh_ok && w_fwd_hit) || (r_state == WAIT);
  assign w_commit_addr = w_in_idle ? wb.wb_addr : r_addr;

  // Merge base is the held row on the forwarded path, SRAM data otherwise.
  assign w_base = w_in_idle ? r_fwd_row    : mem_rd_data;
  assign w_sel  = w_in_idle ? wb.wb_oneHot : r_onehot;
  assign w_mval = w_in_idle ? wb.wb_val    : r_val;

  y_lane_merge u_merge (
    .base_row   (w_base),
    .oneHot     (w_sel),
    .val        (w_mval),
    .merged_row (w_merged)
  );

  // Completion fires when the next cycle is an idle one with nothing accepted now.
  assign w_next_idle = (w_in_idle && !(w_accept && w_oh_ok)) || (r_state == WRITE);
  assign w_done_fire = w_next_idle && !w_accept && (r_last_pend || wb.wb_lastIn);

  // Control FSM, registered memory strobes, forwarding register and status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_alldone   <= 1'b0;
      r_last_pend <= 1'b0;
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_row   <= '0;
      r_addr      <= '0;
      r_onehot    <= '0;
      r_val       <= '0;
    end else begin
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_alldone   <= w_done_fire;
      r_last_pend <= (r_last_pend | wb.wb_lastIn) & ~w_done_fire;

      if (w_commit) begin
        r_wr_en     <= 1'b1;
        r_wr_addr   <= w_commit_addr;
        r_wr_data   <= w_merged;
        r_fwd_valid <= 1'b1;
        r_fwd_addr  <= w_commit_addr;
        r_fwd_row   <= w_merged;
        r_count     <= sat_inc(r_count);
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_oh_ok) begin
              r_err <= 1'b1;
            end else begin
              r_addr   <= wb.wb_addr;
              r_onehot <= wb.wb_oneHot;
              r_val    <= wb.wb_val;
              r_ready  <= 1'b0;
              if (w_fwd_hit) begin
                r_state <= WRITE;
              end else begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= wb.wb_addr;
                r_state   <= READ;
              end
            end
          end
        end
        READ:  r_state <= WAIT;
        WAIT:  r_state <= WRITE;
        WRITE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb.wb_ready  = r_ready;
  assign mem_rd_en    = r_rd_en;
  assign mem_rd_addr  = r_rd_addr;
  assign mem_wr_en    = r_wr_en;
  assign mem_wr_addr  = r_wr_addr;
  assign mem_wr_data  = r_wr_data;
  assign wb_count     = r_count;
  assign wb_err       = r_err;
  assign wb_allDone   = r_alldone;

endmodule

// File: tb/tb_y_sram_writeback.sv
// Directed bench for y_sram_writeback with a small behavioural Y SRAM.
module tb_y_sram_writeback;
  import y_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  y_row_t            mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  y_row_t            mem_wr_data;
  logic [15:0]       wb_count;
  logic              wb_err;
  logic              wb_allDone;

  always #5 clock = ~clock;

  y_sram_writeback_if wbi ();

  y_sram_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .wb          (wbi.slave),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .wb_count    (wb_count),
    .wb_err      (wb_err),
    .wb_allDone  (wb_allDone)
  );

  localparam y_row_t P7  = {4{64'hC0DE_0707_1111_2222}};
  localparam y_row_t P8  = {4{64'h0808_3333_4444_5555}};
  localparam y_row_t P11 = {4{64'hBEEF_1B1B_6666_7777}};

  function automatic y_row_t init_row(input int a);
    case (a)
      5:       return '1;
      7:       return P7;
      8:       return P8;
      11:      return P11;
      default: return '0;
    endcase
  endfunction

  // Y SRAM model: one-cycle read latency, write on strobe.
  y_row_t mem [16];
  bit     wrote [16];
  always @(posedge clock) begin
    if (mem_rd_en)
      mem_rd_data <= wrote[mem_rd_addr[3:0]] ? mem[mem_rd_addr[3:0]] : init_row(int'(mem_rd_addr[3:0]));
    if (mem_wr_en) begin
      mem[mem_wr_addr[3:0]]   <= mem_wr_data;
      wrote[mem_wr_addr[3:0]] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  int                rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int                rd_cyc = -100, wr_cyc = -100, done_cyc = -100;
  y_row_t            wr_row = '0;
  logic [ADDR_W-1:0] wr_a = '0;
  always @(negedge clock) begin
    if (mem_rd_en) begin
      rd_cnt = rd_cnt + 1;
      rd_cyc = cyc;
    end
    if (mem_wr_en) begin
      wr_cnt = wr_cnt + 1;
      wr_cyc = cyc;
      wr_row = mem_wr_data;
      wr_a   = mem_wr_addr;
    end
    if (wb_allDone) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!wbi.wb_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_timeout", 256'(wbi.wb_ready), 256'(1));
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [3:0] oh,
                      input logic [VAL_W-1:0] v, input logic last, output int t);
    wait_ready();
    wbi.wb_valid  = 1'b1;
    wbi.wb_addr   = a;
    wbi.wb_oneHot = oh;
    wbi.wb_val    = v;
    wbi.wb_lastIn = last;
    t = cyc;
    tick();
    wbi.wb_valid  = 1'b0;
    wbi.wb_lastIn = 1'b0;
  endtask

  initial begin
    int     t, t2, r0, w0, d0;
    y_row_t exp5, exp7, exp8;

    wbi.wb_valid  = 1'b0;
    wbi.wb_addr   = '0;
    wbi.wb_oneHot = '0;
    wbi.wb_val    = '0;
    wbi.wb_lastIn = 1'b0;
    reset = 1'b1;
    repeat (2) tick();

    chk("rst_ready", 256'(wbi.wb_ready), 256'(1));
    chk("rst_rd_en", 256'(mem_rd_en), 256'(0));
    chk("rst_wr_en", 256'(mem_wr_en), 256'(0));
    chk("rst_count", 256'(wb_count), 256'(0));
    chk("rst_err", 256'(wb_err), 256'(0));
    chk("rst_done", 256'(wb_allDone), 256'(0));
    chk("rst_wdata", mem_wr_data, 256'(0));
    reset = 1'b0;
    tick();

    // 1: normal read-modify-write of row 5
    exp5 = '1;
    exp5[111:64] = 48'h123456_ABCDEF;
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(11'd5, 4'b0010, 48'h123456_ABCDEF, 1'b0, t);
    wait_ready();
    chk("t1_rd_lat", 256'(rd_cyc - t), 256'(1));
    chk("t1_wr_lat", 256'(wr_cyc - t), 256'(3));
    chk("t1_row", wr_row, exp5);
    chk("t1_waddr", 256'(wr_a), 256'(5));
    chk("t1_count", 256'(wb_count), 256'(1));
    chk("t1_nrd", 256'(rd_cnt - r0), 256'(1));
    chk("t1_nwr", 256'(wr_cnt - w0), 256'(1));

    // 2: back-to-back updates of the forwarded row
    r0 = rd_cnt;
    send(11'd5, 4'b0001, 48'hAAAA_0000_5555, 1'b0, t);
    wait_ready();
    exp5[47:0] = 48'hAAAA_0000_5555;
    chk("t2a_wr_lat", 256'(wr_cyc - t), 256'(1));
    chk("t2a_row", wr_row, exp5);
    send(11'd5, 4'b1000, 48'h0F0F_F0F0_1234, 1'b0, t2);
    chk("t2_gap", 256'(t2 - t), 256'(2));
    wait_ready();
    exp5[239:192] = 48'h0F0F_F0F0_1234;
    chk("t2b_wr_lat", 256'(wr_cyc - t2), 256'(1));
    chk("t2b_row", wr_row, exp5);
    chk("t2_nrd", 256'(rd_cnt - r0), 256'(0));
    chk("t2_count", 256'(wb_count), 256'(3));

    // 3: different rows, forwarding moves to the newest row
    exp7 = P7;
    exp7[175:128] = 48'hCCCC_1111_2222;
    r0 = rd_cnt;
    send(11'd7, 4'b0100, 48'hCCCC_1111_2222, 1'b0, t);
    wait_ready();
    chk("t3a_row", wr_row, exp7);
    chk("t3a_nrd", 256'(rd_cnt - r0), 256'(1));
    send(11'd8, 4'b0010, 48'hDDDD_3333_4444, 1'b0, t2);
    chk("t3_gap", 256'(t2 - t), 256'(4));
    wait_ready();
    exp8 = P8;
    exp8[111:64] = 48'hDDDD_3333_4444;
    chk("t3b_row", wr_row, exp8);
    chk("t3b_nrd", 256'(rd_cnt - r0), 256'(2));
    send(11'd7, 4'b0001, 48'hEEEE_5555_6666, 1'b0, t);
    wait_ready();
    exp7[47:0] = 48'hEEEE_5555_6666;
    chk("t3c_rd_lat", 256'(rd_cyc - t), 256'(1));
    chk("t3c_row", wr_row, exp7);
    chk("t3c_nrd", 256'(rd_cnt - r0), 256'(3));
    chk("t3_count", 256'(wb_count), 256'(6));

    // 4: bad lane selects
    r0 = rd_cnt;
    w0 = wr_cnt;
    send(11'd9, 4'b0000, 48'h1, 1'b0, t);
    repeat (3) tick();
    chk("t4a_err", 256'(wb_err), 256'(1));
    chk("t4a_ready", 256'(wbi.wb_ready), 256'(1));
    send(11'd9, 4'b0110, 48'h2, 1'b0, t);
    repeat (3) tick();
    chk("t4b_err", 256'(wb_err), 256'(1));
    chk("t4_count", 256'(wb_count), 256'(6));
    chk("t4_nrd", 256'(rd_cnt - r0), 256'(0));
    chk("t4_nwr", 256'(wr_cnt - w0), 256'(0));

    // 5: wb_lastIn during WAIT of the last request
    d0 = done_cnt;
    send(11'd10, 4'b0010, 48'hF00D_0000_0001, 1'b0, t);
    tick();
    wbi.wb_lastIn = 1'b1;
    tick();
    wbi.wb_lastIn = 1'b0;
    repeat (6) tick();
    chk("t5_wr_lat", 256'(wr_cyc - t), 256'(3));
    chk("t5_done_cyc", 256'(done_cyc - t), 256'(4));
    chk("t5_done_n", 256'(done_cnt - d0), 256'(1));
    chk("t5_done_low", 256'(wb_allDone), 256'(0));
    chk("t5_count", 256'(wb_count), 256'(7));

    // 5b: wb_lastIn in the same cycle as an accept
    d0 = done_cnt;
    send(11'd5, 4'b0100, 48'h4444_5555_6666, 1'b1, t);
    repeat (6) tick();
    exp5[175:128] = 48'h4444_5555_6666;
    chk("t5b_row", wr_row, exp5);
    chk("t5b_done_cyc", 256'(done_cyc - t), 256'(4));
    chk("t5b_done_n", 256'(done_cnt - d0), 256'(1));
    chk("t5b_count", 256'(wb_count), 256'(8));

    // 6: reset during WAIT
    w0 = wr_cnt;
    send(11'd11, 4'b0001, 48'h9999_8888_7777, 1'b0, t);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_ready", 256'(wbi.wb_ready), 256'(1));
    chk("t6_rd_en", 256'(mem_rd_en), 256'(0));
    chk("t6_wr_en", 256'(mem_wr_en), 256'(0));
    chk("t6_count", 256'(wb_count), 256'(0));
    chk("t6_err", 256'(wb_err), 256'(0));
    chk("t6_done", 256'(wb_allDone), 256'(0));
    chk("t6_wdata", mem_wr_data, 256'(0));
    chk("t6_raddr", 256'(mem_rd_addr), 256'(0));
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("t6_nwr", 256'(wr_cnt - w0), 256'(0));
    chk("t6_ready_post", 256'(wbi.wb_ready), 256'(1));

    // forwarding was cleared by reset: row 5 must be read again
    r0 = rd_cnt;
    send(11'd5, 4'b0010, 48'h0123_4567_89AB, 1'b0, t);
    wait_ready();
    exp5[111:64] = 48'h0123_4567_89AB;
    chk("t6_fwd_clr_nrd", 256'(rd_cnt - r0), 256'(1));
    chk("t6_fwd_clr_row", wr_row, exp5);
    chk("t6_count_post", 256'(wb_count), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
